ssio_ddr_in_align: RTL and testbench
====================================

Name: ssio_ddr_in_align

Overview:
- Receive-side companion to the source-synchronous DDR output path.
- Sits directly after the per-bit input DDR capture, which delivers one rising-edge sample (d1) and one falling-edge sample (d2) per clk cycle.
- The capture may pair samples off by a half cycle; this block detects the pairing from a training pattern and then emits correctly paired (first, second) samples with a matching valid.
- A lock state machine controls when aligned data is released.

Parameters:
- WIDTH, 4, data bits per edge.
- TRAIN_D1, 4'h5, expected first-edge training value (WIDTH bits).
- TRAIN_D2, 4'hD, expected second-edge training value (WIDTH bits); must differ from TRAIN_D1.
- LOCK_COUNT, 3, consecutive matching training pairs required to lock (1..255).

Ports:
- clk, input, 1, receive clock; all logic is on its rising edge.
- rst, input, 1, synchronous active-high reset.
- input_d1, input, WIDTH, rising-edge sample for this cycle.
- input_d2, input, WIDTH, falling-edge sample for this cycle.
- input_v1, input, 1, valid/control sampled with input_d1.
- input_v2, input, 1, valid/control sampled with input_d2.
- realign, input, 1, single-cycle pulse that drops lock and restarts the search.
- output_d1, output, WIDTH, aligned first-edge sample.
- output_d2, output, WIDTH, aligned second-edge sample.
- output_valid, output, 1, aligned pair valid.
- locked, output, 1, alignment is established.
- swapped, output, 1, 1 = pairs are formed as (previous d2, current d1).
- err_count, output, 16, misalignment error count (see Optional Feature).

Behaviour:
- Reset: one clock and one reset; the reset is synchronous and active-high (rst). While rst is high on a clk edge, the following clear:
  - all outputs go to 0;
  - the state goes to SEARCH;
  - the match counter clears;
  - d1_r, d2_r, v1_r and v2_r clear.
- Pipeline: every cycle, d1_r, d2_r, v1_r and v2_r take input_d1, input_d2, input_v1 and input_v2.
- Candidate pairs, evaluated every cycle:
  - N (normal) = (d1_r, d2_r), valid = v1_r & v2_r.
  - S (swapped) = (d2_r, input_d1), valid = v2_r & input_v1.
- Latency:
  - The output registers update on the edge after the cycle in which the pair's second half arrives.
  - The pair starting in input cycle n appears on the outputs after edge n+2, for both alignments.
- SEARCH state:
  - output_valid = 0 and locked = 0.
  - N matches if its valid is 1 and it equals (TRAIN_D1, TRAIN_D2); S matches under the same rule.
  - If N matches, count the N alignment; otherwise, if S matches, count the S alignment.
  - The counter increments if the same alignment matched in the previous cycle; otherwise it loads 1 with the new alignment recorded.
  - If neither matches, the counter clears.
  - When the counter reaches LOCK_COUNT, the next state is LOCKED, swapped takes the recorded alignment, and the counter holds.
- LOCKED state:
  - locked = 1.
  - Every cycle, output_d1 and output_d2 take the selected pair (N if swapped = 0, else S), and output_valid takes that pair's valid.
  - No data-dependent unlock occurs.
- realign:
  - When realign = 1 in any state, the next state is SEARCH, the counter clears and locked falls on that edge.
  - output_valid is 0 from that edge.
  - swapped holds its old value until a new lock is reached.
  - rst takes priority over realign.
- Simultaneous lock and realign: realign wins and the state stays SEARCH.
- Data registers, output_d1 and output_d2, load every cycle in LOCKED only; in SEARCH they hold their last value.

Optional Feature:
- Macro: SSIO_DDR_IN_ALIGN_ERR_EN.
- Defined:
  - In LOCKED, a cycle counts as an error when the unselected candidate's valid is 1 and the selected candidate's valid is 0 (a half-cycle-shifted frame edge).
  - err_count increments on each error and saturates at 16'hFFFF.
  - err_count clears on rst or realign.
- Not defined: err_count is a constant 0 and no counter logic is generated.

Test Plan:
- Normal lock: rst, then feed (d1, d2, v1, v2) = (5, D, 1, 1) for 3 cycles, then data (1,2),(3,4) with v = 1. Required: locked = 1, swapped = 0, output pairs (1,2),(3,4) each appearing 2 edges after input, output_valid = 1.
- Swapped lock: feed d2 = 5 then next-cycle d1 = D, repeated 3 times, with v high. Required: locked = 1, swapped = 1. Then feed d2 = 7 (cycle k) and d1 = 8 (cycle k+1); output (7,8) appears after edge k+2.
- Broken training: feed 2 matches, 1 non-match, then 2 matches. Required: locked stays 0 and output_valid stays 0. A third consecutive match locks.
- Realign: while locked with swapped = 1, pulse realign. Required: locked = 0 and output_valid = 0 on the next edge; swapped stays 1. Normal training then relocks with swapped = 0.
- Reset mid-lock: assert rst for 1 cycle while locked. Required: all outputs 0 and SEARCH state; realign asserted in the same cycle has no extra effect.
- With SSIO_DDR_IN_ALIGN_ERR_EN defined: lock normal, then feed v1 = 0, v2 = 1 followed by v1 = 1, v2 = 0, 4 times. Required: err_count = 4. Without the macro, err_count = 0 throughout.

Source files
------------

// File: rtl/ssio_ddr_in_align_if.sv
// Bus bundle for ssio_ddr_in_align: raw DDR capture samples in,
// aligned sample pairs and lock status out.
// master = the side producing captured samples and consuming aligned pairs,
// slave  = the alignment block itself.
interface ssio_ddr_in_align_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] input_d1;
   logic [WIDTH-1:0] input_d2;
   logic             input_v1;
   logic             input_v2;
   logic             realign;
   logic [WIDTH-1:0] output_d1;
   logic [WIDTH-1:0] output_d2;
   logic             output_valid;
   logic             locked;
   logic             swapped;
   logic [15:0]      err_count;

   modport master (
      output input_d1, input_d2, input_v1, input_v2, realign,
      input  output_d1, output_d2, output_valid, locked, swapped, err_count
   );

   modport slave (
      input  input_d1, input_d2, input_v1, input_v2, realign,
      output output_d1, output_d2, output_valid, locked, swapped, err_count
   );
endinterface

// File: rtl/ssio_ddr_in_align.sv
// ssio_ddr_in_align: pairs the rising/falling samples of an input DDR
// capture correctly. A training pattern (TRAIN_D1 then TRAIN_D2) is searched
// for in both possible pairings: normal (d1, d2 of the same cycle) and
// swapped (d2 of one cycle, d1 of the next). Once LOCK_COUNT consecutive
// pairs match in one pairing, that pairing is frozen and data is released.
// Optional: define SSIO_DDR_IN_ALIGN_ERR_EN to count half-cycle-shifted
// frame edges seen while locked on err_count.
module ssio_ddr_in_align #(
   parameter int               WIDTH      = 4,
   parameter logic [WIDTH-1:0] TRAIN_D1   = 4'h5,
   parameter logic [WIDTH-1:0] TRAIN_D2   = 4'hD,
   parameter int               LOCK_COUNT = 3
) (
   input logic               clk,
   input logic               rst,
   ssio_ddr_in_align_if.slave bus
);

   typedef enum logic {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam logic [7:0] LOCK_TARGET = 8'(LOCK_COUNT);

   // one-cycle history of the capture, needed to build both pairings
   logic [WIDTH-1:0] d1_r;
   logic [WIDTH-1:0] d2_r;
   logic             v1_r;
   logic             v2_r;

   // candidate pairs
   logic [WIDTH-1:0] n_d1, n_d2, s_d1, s_d2;
   logic             n_v, s_v;
   logic             n_match, s_match;

   // search bookkeeping
   state_t     state;
   logic [7:0] match_cnt;
   logic       align_rec;   // alignment of the current match run, 1 = swapped
   logic       hit;
   logic       hit_swapped;
   logic [7:0] cnt_next;

   // selected pair while locked
   logic [WIDTH-1:0] sel_d1, sel_d2;
   logic             sel_v, unsel_v;

   // registered outputs
   logic [WIDTH-1:0] out_d1_q;
   logic [WIDTH-1:0] out_d2_q;
   logic             out_valid_q;
   logic             locked_q;
   logic             swapped_q;

   // capture history register
   always_ff @(posedge clk) begin
      if (rst) begin
         d1_r <= '0;
         d2_r <= '0;
         v1_r <= 1'b0;
         v2_r <= 1'b0;
      end else begin
         d1_r <= bus.input_d1;
         d2_r <= bus.input_d2;
         v1_r <= bus.input_v1;
         v2_r <= bus.input_v2;
      end
   end

   // both pairings; the swapped one borrows the current rising sample so
   // that both pairings reach the outputs with the same latency
   always_comb begin
      n_d1    = d1_r;
      n_d2    = d2_r;
      n_v     = v1_r & v2_r;
      s_d1    = d2_r;
      s_d2    = bus.input_d1;
      s_v     = v2_r & bus.input_v1;
      n_match = n_v && (n_d1 == TRAIN_D1) && (n_d2 == TRAIN_D2);
      s_match = s_v && (s_d1 == TRAIN_D1) && (s_d2 == TRAIN_D2);
   end

   // next match-run length; normal pairing wins when both happen to match.
   // A nonzero count always means the previous cycle matched, because any
   // miss clears it and every entry into SEARCH starts from zero.
   always_comb begin
      hit         = n_match | s_match;
      hit_swapped = ~n_match & s_match;
      cnt_next    = 8'd0;
      if (hit) begin
         if ((match_cnt != 8'd0) && (align_rec == hit_swapped))
            cnt_next = match_cnt + 8'd1;
         else
            cnt_next = 8'd1;
      end
   end

   // pick the locked-in pairing
   always_comb begin
      if (swapped_q) begin
         sel_d1  = s_d1;
         sel_d2  = s_d2;
         sel_v   = s_v;
         unsel_v = n_v;
      end else begin
         sel_d1  = n_d1;
         sel_d2  = n_d2;
         sel_v   = n_v;
         unsel_v = s_v;
      end
   end

   // lock state machine with registered outputs; realign overrides a
   // lock that would otherwise happen on the same edge
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= SEARCH;
         match_cnt   <= 8'd0;
         align_rec   <= 1'b0;
         locked_q    <= 1'b0;
         swapped_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_d1_q    <= '0;
         out_d2_q    <= '0;
      end else if (bus.realign) begin
         state       <= SEARCH;
         match_cnt   <= 8'd0;
         locked_q    <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            SEARCH: begin
               out_valid_q <= 1'b0;
               locked_q    <= 1'b0;
               match_cnt   <= cnt_next;
               if (hit)
                  align_rec <= hit_swapped;
               if (cnt_next == LOCK_TARGET) begin
                  state     <= LOCKED;
                  locked_q  <= 1'b1;
                  swapped_q <= hit_swapped;
               end
            end
            LOCKED: begin
               locked_q    <= 1'b1;
               out_d1_q    <= sel_d1;
               out_d2_q    <= sel_d2;
               out_valid_q <= sel_v;
            end
            default: begin
               state    <= SEARCH;
               locked_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.output_d1    = out_d1_q;
   assign bus.output_d2    = out_d2_q;
   assign bus.output_valid = out_valid_q;
   assign bus.locked       = locked_q;
   assign bus.swapped      = swapped_q;

`ifdef SSIO_DDR_IN_ALIGN_ERR_EN
   logic [15:0] err_q;
   logic        err_hit;

   // a valid frame seen only in the other pairing means the capture slipped
   assign err_hit = (state == LOCKED) & unsel_v & ~sel_v;

   // saturating error counter, cleared by reset or realign
   always_ff @(posedge clk) begin
      if (rst || bus.realign)
         err_q <= 16'd0;
      else if (err_hit && (err_q != 16'hFFFF))
         err_q <= err_q + 16'd1;
   end

   assign bus.err_count = err_q;
`else
   assign bus.err_count = 16'd0;
`endif

endmodule

// File: tb/tb_ssio_ddr_in_align.sv
// Self-checking bench for ssio_ddr_in_align. Directed scenarios followed by
// randomized traffic; every cycle all outputs are compared against a
// stream-level reference model of the alignment rules.
module tb_ssio_ddr_in_align;

   localparam int         W  = 4;
   localparam logic [3:0] T1 = 4'h5;
   localparam logic [3:0] T2 = 4'hD;
   localparam int         LC = 3;
`ifdef SSIO_DDR_IN_ALIGN_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ssio_ddr_in_align_if #(.WIDTH(W)) bus ();

   ssio_ddr_in_align #(
      .WIDTH(W), .TRAIN_D1(T1), .TRAIN_D2(T2), .LOCK_COUNT(LC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // reference model: previous cycle's half-samples plus lock status
   logic [3:0]  m_pd1 = '0, m_pd2 = '0;
   logic        m_pv1 = 1'b0, m_pv2 = 1'b0;
   logic        m_locked = 1'b0, m_swapped = 1'b0, m_ov = 1'b0;
   logic [3:0]  m_od1 = '0, m_od2 = '0;
   logic [15:0] m_err = '0;
   int          m_run = 0;
   logic        m_run_sw = 1'b0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one clock of the model, given what was presented on that edge
   task automatic model_step(input logic [3:0] d1, d2, input logic v1, v2, ra, rs);
      logic n_ok, s_ok, sel_v, oth_v;
      if (rs) begin
         m_pd1 = '0; m_pd2 = '0; m_pv1 = 0; m_pv2 = 0;
         m_locked = 0; m_swapped = 0; m_ov = 0; m_od1 = '0; m_od2 = '0;
         m_err = '0; m_run = 0; m_run_sw = 0;
         return;
      end
      // normal pair = last cycle's two halves; swapped pair = last falling
      // half followed by this cycle's rising half
      n_ok = m_pv1 && m_pv2 && m_pd1 == T1 && m_pd2 == T2;
      s_ok = m_pv2 && v1 && m_pd2 == T1 && d1 == T2;
      if (ra) begin
         m_locked = 0; m_ov = 0; m_run = 0; m_err = '0;
      end else if (!m_locked) begin
         m_ov = 0;
         if (n_ok) begin
            m_run = (m_run > 0 && !m_run_sw) ? m_run + 1 : 1; m_run_sw = 0;
         end else if (s_ok) begin
            m_run = (m_run > 0 && m_run_sw) ? m_run + 1 : 1; m_run_sw = 1;
         end else
            m_run = 0;
         if (m_run == LC) begin
            m_locked = 1; m_swapped = m_run_sw;
         end
      end else begin
         if (!m_swapped) begin
            m_od1 = m_pd1; m_od2 = m_pd2; sel_v = m_pv1 & m_pv2; oth_v = m_pv2 & v1;
         end else begin
            m_od1 = m_pd2; m_od2 = d1; sel_v = m_pv2 & v1; oth_v = m_pv1 & m_pv2;
         end
         m_ov = sel_v;
         if (ERR_EN && oth_v && !sel_v && m_err != 16'hFFFF) m_err = m_err + 16'd1;
      end
      m_pd1 = d1; m_pd2 = d2; m_pv1 = v1; m_pv2 = v2;
   endtask

   task automatic check_all();
      chk("out_d1",    16'(bus.output_d1),    16'(m_od1));
      chk("out_d2",    16'(bus.output_d2),    16'(m_od2));
      chk("out_valid", 16'(bus.output_valid), 16'(m_ov));
      chk("locked",    16'(bus.locked),       16'(m_locked));
      chk("swapped",   16'(bus.swapped),      16'(m_swapped));
      chk("err_count", bus.err_count,         m_err);
   endtask

   // present one cycle of inputs, clock it, then compare #1 after the edge
   task automatic step(input logic [3:0] d1, d2, input logic v1 = 1, v2 = 1,
                       input logic ra = 0, rs = 0);
      bus.input_d1 = d1; bus.input_d2 = d2;
      bus.input_v1 = v1; bus.input_v2 = v2;
      bus.realign  = ra; rst = rs;
      @(posedge clk);
      model_step(d1, d2, v1, v2, ra, rs);
      #1;
      check_all();
   endtask

   initial begin
      int         burst_left;
      logic       burst_sw;
      logic [3:0] rd1, rd2;
      logic       rv1, rv2, rra, rrs;

      bus.input_d1 = '0; bus.input_d2 = '0;
      bus.input_v1 = 0;  bus.input_v2 = 0;
      bus.realign  = 0;

      // reset
      step(4'h0, 4'h0, 0, 0, 0, 1);
      step(4'h0, 4'h0, 0, 0, 0, 1);
      chk("rst_locked", 16'(bus.locked), 16'd0);
      chk("rst_valid",  16'(bus.output_valid), 16'd0);

      // normal lock, data 2 edges after input
      step(T1, T2); step(T1, T2); step(T1, T2);
      step(4'h1, 4'h2);
      chk("norm_locked",  16'(bus.locked), 16'd1);
      chk("norm_swapped", 16'(bus.swapped), 16'd0);
      step(4'h3, 4'h4);
      chk("norm_pair1", 16'({bus.output_valid, bus.output_d1, bus.output_d2}), 16'h112);
      step(4'h0, 4'h0);
      chk("norm_pair2", 16'({bus.output_valid, bus.output_d1, bus.output_d2}), 16'h134);

      // drop lock, then swapped lock
      step(4'h0, 4'h0, 1, 1, 1);
      chk("ra_locked", 16'(bus.locked), 16'd0);
      step(4'h0, T1); step(T2, T1); step(T2, T1); step(T2, 4'h0);
      chk("sw_locked",  16'(bus.locked), 16'd1);
      chk("sw_swapped", 16'(bus.swapped), 16'd1);
      step(4'h0, 4'h7); step(4'h8, 4'h0);
      chk("sw_pair", 16'({bus.output_valid, bus.output_d1, bus.output_d2}), 16'h178);

      // realign while swapped: swapped holds
      step(4'h0, 4'h0, 1, 1, 1);
      chk("ra2_locked",  16'(bus.locked), 16'd0);
      chk("ra2_valid",   16'(bus.output_valid), 16'd0);
      chk("ra2_swapped", 16'(bus.swapped), 16'd1);

      // broken training, then relock normal
      step(T1, T2); step(T1, T2); step(4'h0, 4'h0);
      step(T1, T2); step(T1, T2); step(T1, T2);
      chk("broken_locked", 16'(bus.locked), 16'd0);
      chk("broken_valid",  16'(bus.output_valid), 16'd0);
      step(4'h9, 4'hA);
      chk("relock_locked",  16'(bus.locked), 16'd1);
      chk("relock_swapped", 16'(bus.swapped), 16'd0);

      // reset mid-lock with realign together
      step(4'h0, 4'h0, 1, 1, 1, 1);
      chk("rstlock_all", 16'({bus.locked, bus.swapped, bus.output_valid,
                             bus.output_d1, bus.output_d2}), 16'd0);

      // frame-edge errors while locked normal
      step(T1, T2); step(T1, T2); step(T1, T2);
      for (int i = 0; i < 4; i++) begin
         step(4'h1, 4'h2, 0, 1);
         step(4'h3, 4'h4, 1, 0);
      end
      step(4'h0, 4'h0); step(4'h0, 4'h0);
      chk("err_total", bus.err_count, ERR_EN ? 16'd4 : 16'd0);

      // randomized traffic with occasional training bursts in either pairing
      burst_left = 0; burst_sw = 0;
      for (int c = 0; c < 3000; c++) begin
         if (burst_left == 0 && $urandom_range(0, 15) == 0) begin
            burst_left = int'($urandom_range(3, 5));
            burst_sw   = 1'($urandom_range(0, 1));
         end
         if (burst_left > 0) begin
            burst_left--;
            rd1 = burst_sw ? T2 : T1;
            rd2 = burst_sw ? T1 : T2;
            rv1 = 1; rv2 = 1;
         end else begin
            rd1 = 4'($urandom_range(0, 15));
            rd2 = 4'($urandom_range(0, 15));
            rv1 = ($urandom_range(0, 7) != 0);
            rv2 = ($urandom_range(0, 7) != 0);
         end
         rra = ($urandom_range(0, 39) == 0);
         rrs = ($urandom_range(0, 199) == 0);
         step(rd1, rd2, rv1, rv2, rra, rrs);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
